sync_seq_driver: RTL

- Initiator/caller side of the valid/ready sync protocol used by generated function blocks such as fib.
- Accepts a command (start argument, step, count) and issues `count` sequential calls to an attached sync function block, one outstanding call at a time.
- Streams each result out with its own handshake, then reports a wrapped sum and an error flag.
- Sits between a host/sequencer and any single-input, single-output generated function block; it replaces hand-written bench stimulus.

---
 rtl/sync_seq_driver.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sync_seq_driver.sv
// Caller side of the valid/ready sync protocol: turns one command into `count`
// sequential calls to a function block and streams each result downstream.
module sync_seq_driver #(
   parameter int WIDTH   = 16,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_start,
   input  logic [WIDTH-1:0] cmd_step,
   input  logic [CNT_W-1:0] cmd_count,
   output logic             dut_in_valid,
   input  logic             dut_in_ready,
   output logic [WIDTH-1:0] dut_in0,
   input  logic             dut_out_valid,
   output logic             dut_out_ready,
   input  logic [WIDTH-1:0] dut_out0,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [CNT_W-1:0] res_idx,
   output logic             res_last,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_EMIT  = 3'd3;
   localparam logic [2:0] S_FIN   = 3'd4;

   localparam int TCNT_W = $clog2(TIMEOUT + 1);

   logic [2:0]        state;
   logic [WIDTH-1:0]  arg;
   logic [WIDTH-1:0]  step_q;
   logic [WIDTH-1:0]  res_q;
   logic [WIDTH-1:0]  sum_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  idx;
   logic [TCNT_W-1:0] tcnt;
   logic              err_q;
   logic              is_last;

   // count_q is never 0 while in EMIT, so count_q-1 cannot underflow there.
   assign is_last = (idx == count_q - CNT_W'(1));

   assign cmd_ready     = (state == S_IDLE);
   assign dut_in_valid  = (state == S_ISSUE);
   assign dut_out_ready = (state == S_WAIT);
   assign res_valid     = (state == S_EMIT);
   assign res_last      = (state == S_EMIT) && is_last;
   assign done          = (state == S_FIN);
   assign dut_in0       = arg;
   assign res_data      = res_q;
   assign res_idx       = idx;
   assign sum           = sum_q;
   assign err           = err_q;

   // NOTE: state registers use non-blocking assignments only, so every branch
   // below reads the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         arg     <= '0;
         step_q  <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         count_q <= '0;
         idx     <= '0;
         tcnt    <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (cmd_valid) begin
               arg     <= cmd_start;
               step_q  <= cmd_step;
               count_q <= cmd_count;
               sum_q   <= '0;
               err_q   <= 1'b0;
               idx     <= '0;
               state   <= (cmd_count == '0) ? S_FIN : S_ISSUE;
            end
            S_ISSUE: if (dut_in_ready) begin
               tcnt  <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (dut_out_valid) begin
                  res_q <= dut_out0;
                  sum_q <= sum_q + dut_out0;
                  state <= S_EMIT;
               end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                  // TIMEOUT idle WAIT cycles have now elapsed; abandon the call.
                  err_q <= 1'b1;
                  state <= S_FIN;
               end else begin
                  tcnt <= tcnt + TCNT_W'(1);
               end
            end
            S_EMIT: if (res_ready) begin
               if (is_last) begin
                  state <= S_FIN;
               end else begin
                  idx   <= idx + CNT_W'(1);
                  arg   <= arg + step_q;
                  state <= S_ISSUE;
               end
            end
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
